// File: rtl/irq_rr_dispatcher_if.sv
// Vector offer / end-of-interrupt handshake between the
// round-robin dispatcher (master) and its single consumer (slave).
interface irq_rr_dispatcher_if #(
    parameter int IDW = 8
);
    logic           VEC_VALID;
    logic [IDW-1:0] VEC_ID;
    logic           VEC_ACK;
    logic           EOI_VALID;
    logic [IDW-1:0] EOI_ID;

    modport master (
        output VEC_VALID, VEC_ID,
        input  VEC_ACK, EOI_VALID, EOI_ID
    );

    modport slave (
        input  VEC_VALID, VEC_ID,
        output VEC_ACK, EOI_VALID, EOI_ID
    );
endinterface

// File: rtl/irq_rr_dispatcher.sv
// Round-robin IRQ dispatcher: latches edge lines, offers one eligible
// line at a time over valid/ack, tracks acked lines until EOI.
module irq_rr_dispatcher #(
    parameter int IRQ_CNT = 240,
    parameter int IDW     = (IRQ_CNT > 1) ? $clog2(IRQ_CNT) : 1
) (
    input  logic                CLK,
    input  logic                RESETn,
    input  logic [IRQ_CNT-1:0]  IRQ,
    input  logic [IRQ_CNT-1:0]  EDGE_SEL,
    input  logic [IRQ_CNT-1:0]  MASK,
    irq_rr_dispatcher_if.master vec,
    output logic [IRQ_CNT-1:0]  ACTIVE,
    output logic                ANY_ELIG
);

    typedef enum logic {
        IDLE,
        OFFER
    } state_e;

    localparam logic [IDW:0]   CNT  = (IDW+1)'(IRQ_CNT);
    localparam logic [IDW-1:0] LAST = IDW'(IRQ_CNT - 1);
    localparam logic [IDW-1:0] ONE  = IDW'(1);

    state_e               state_q, state_d;
    logic [IRQ_CNT-1:0]   irq_q, irq_d;
    logic [IRQ_CNT-1:0]   epend_q, epend_d;
    logic [IRQ_CNT-1:0]   active_q, active_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       vec_id_q, vec_id_d;

    logic [IRQ_CNT-1:0]   pend;
    logic [IRQ_CNT-1:0]   elig;
    logic [2*IRQ_CNT-1:0] elig_dbl;
    logic [IRQ_CNT-1:0]   elig_rot;
    logic [IDW-1:0]       off;
    logic [IDW:0]         win_raw;
    logic [IDW:0]         win_mod;
    logic [IDW-1:0]       win;

    // Pending / eligible vectors from latched edges or sampled levels.
    always_comb begin
        pend = (EDGE_SEL & epend_q) | (~EDGE_SEL & irq_q);
        elig = pend & MASK & ~active_q;
    end

    // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        elig_dbl = {elig, elig} >> ptr_q;
        elig_rot = elig_dbl[IRQ_CNT-1:0];
        off      = '0;
        for (int i = IRQ_CNT - 1; i >= 0; i--) begin
            if (elig_rot[i]) begin
                off = IDW'(i);
            end
        end
        win_raw = {1'b0, ptr_q} + {1'b0, off};
        win_mod = (win_raw >= CNT) ? (win_raw - CNT) : win_raw;
        win     = win_mod[IDW-1:0];
    end

    // Offer FSM, active tracking, EOI retirement and edge latching.
    always_comb begin
        state_d  = state_q;
        vec_id_d = vec_id_q;
        ptr_d    = ptr_q;
        active_d = active_q;
        epend_d  = epend_q;
        irq_d    = IRQ;

        // Retire first so a transfer of the same ID below wins.
        if (vec.EOI_VALID && ({1'b0, vec.EOI_ID} < CNT)) begin
            active_d[vec.EOI_ID] = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (|elig) begin
                    vec_id_d = win;
                    state_d  = OFFER;
                end
            end
            OFFER: begin
                if (vec.VEC_ACK) begin
                    active_d[vec_id_q] = 1'b1;
                    epend_d[vec_id_q]  = 1'b0;
                    ptr_d   = (vec_id_q == LAST) ? '0 : vec_id_q + ONE;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new edge overrides the transfer clear; level lines hold no edge.
        epend_d = (epend_d | (EDGE_SEL & IRQ & ~irq_q)) & EDGE_SEL;
    end

    // State registers; async reset drops any outstanding offer at once.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q  <= IDLE;
            irq_q    <= '0;
            epend_q  <= '0;
            active_q <= '0;
            ptr_q    <= '0;
            vec_id_q <= '0;
        end else begin
            state_q  <= state_d;
            irq_q    <= irq_d;
            epend_q  <= epend_d;
            active_q <= active_d;
            ptr_q    <= ptr_d;
            vec_id_q <= vec_id_d;
        end
    end

    assign vec.VEC_VALID = (state_q == OFFER);
    assign vec.VEC_ID    = vec_id_q;
    assign ACTIVE        = active_q;
    assign ANY_ELIG      = |elig;

endmodule

// File: tb/tb_irq_rr_dispatcher.sv
// Bench for irq_rr_dispatcher: directed table, corner sequences and
// randomized traffic against a lockstep behavioural model.
module tb_irq_rr_dispatcher;
    localparam int N   = 240;
    localparam int IDW = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] irq      = '0;
    logic [N-1:0] edge_sel = '0;
    logic [N-1:0] mask     = '0;
    logic [N-1:0] active;
    logic         any_elig;

    int n_checks = 0;
    int n_fail   = 0;

    irq_rr_dispatcher_if #(.IDW(IDW)) bus ();

    irq_rr_dispatcher #(.IRQ_CNT(N), .IDW(IDW)) dut (
        .CLK      (clk),
        .RESETn   (rst_n),
        .IRQ      (irq),
        .EDGE_SEL (edge_sel),
        .MASK     (mask),
        .vec      (bus),
        .ACTIVE   (active),
        .ANY_ELIG (any_elig)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    bit m_ep[N];
    bit m_act[N];
    bit m_prev[N];
    int m_ptr;
    bit m_off;
    int m_id;

    typedef struct {
        bit ack;
        bit eoi_v;
        int eoi_id;
        bit exp_v;
        int exp_id;
        bit exp_a5;
    } vec_t;
    vec_t t1[8];

    task automatic chk(string nm, logic [N-1:0] got, logic [N-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic bit m_elig(int n);
        bit p;
        p = edge_sel[n] ? m_ep[n] : m_prev[n];
        return p && mask[n] && !m_act[n];
    endfunction

    task automatic model_reset();
        for (int n = 0; n < N; n++) begin
            m_ep[n]   = 1'b0;
            m_act[n]  = 1'b0;
            m_prev[n] = 1'b0;
        end
        m_ptr = 0;
        m_off = 1'b0;
        m_id  = 0;
    endtask

    task automatic model_update();
        int win;
        int idx;
        win = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (win < 0 && m_elig(idx)) win = idx;
        end
        if (bus.EOI_VALID && int'(bus.EOI_ID) < N) m_act[bus.EOI_ID] = 1'b0;
        if (m_off) begin
            if (bus.VEC_ACK) begin
                m_act[m_id] = 1'b1;
                m_ep[m_id]  = 1'b0;
                m_ptr       = (m_id + 1) % N;
                m_off       = 1'b0;
            end
        end else if (win >= 0) begin
            m_off = 1'b1;
            m_id  = win;
        end
        for (int n = 0; n < N; n++) begin
            if (edge_sel[n] && irq[n] && !m_prev[n]) m_ep[n] = 1'b1;
            if (!edge_sel[n]) m_ep[n] = 1'b0;
            m_prev[n] = irq[n];
        end
    endtask

    task automatic check_model();
        logic [N-1:0] ea;
        bit any;
        any = 1'b0;
        for (int n = 0; n < N; n++) begin
            ea[n] = m_act[n];
            if (m_elig(n)) any = 1'b1;
        end
        chk("model_valid", N'(bus.VEC_VALID), N'(m_off));
        if (m_off) chk("model_id", N'(bus.VEC_ID), N'(m_id));
        chk("model_active", active, ea);
        chk("model_any_elig", N'(any_elig), N'(any));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        irq           = '0;
        edge_sel      = '0;
        mask          = '0;
        bus.VEC_ACK   = 1'b0;
        bus.EOI_VALID = 1'b0;
        bus.EOI_ID    = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_offer(int exp_id, string nm);
        int t = 0;
        while (!bus.VEC_VALID && t < 20) begin
            step();
            t++;
        end
        chk({nm, "_valid"}, N'(bus.VEC_VALID), N'(1));
        chk({nm, "_id"}, N'(bus.VEC_ID), N'(exp_id));
    endtask

    task automatic ack();
        bus.VEC_ACK = 1'b1;
        step();
        bus.VEC_ACK = 1'b0;
    endtask

    task automatic eoi(int id);
        bus.EOI_VALID = 1'b1;
        bus.EOI_ID    = IDW'(id);
        step();
        bus.EOI_VALID = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] e;
        int cnt;
        int idx;

        t1[0] = '{0, 0, 0, 0, 0, 0};
        t1[1] = '{0, 0, 0, 1, 5, 0};
        t1[2] = '{1, 0, 0, 0, 0, 1};
        t1[3] = '{0, 0, 0, 0, 0, 1};
        t1[4] = '{0, 0, 0, 0, 0, 1};
        t1[5] = '{0, 1, 5, 0, 0, 0};
        t1[6] = '{0, 0, 0, 1, 5, 0};
        t1[7] = '{1, 0, 0, 0, 0, 1};

        // Reset state
        do_reset();
        chk("rst_valid", N'(bus.VEC_VALID), N'(0));
        chk("rst_id", N'(bus.VEC_ID), N'(0));
        chk("rst_active", active, '0);
        chk("rst_ptr", N'(dut.ptr_q), N'(0));
        chk("rst_any_elig", N'(any_elig), N'(0));

        // 1: level line 5, latency, ACK, no re-offer, EOI re-offer
        mask   = '1;
        irq[5] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.VEC_ACK   = t1[i].ack;
            bus.EOI_VALID = t1[i].eoi_v;
            bus.EOI_ID    = IDW'(t1[i].eoi_id);
            step();
            chk($sformatf("t1_valid_%0d", i), N'(bus.VEC_VALID), N'(t1[i].exp_v));
            if (t1[i].exp_v) chk($sformatf("t1_id_%0d", i), N'(bus.VEC_ID), N'(t1[i].exp_id));
            chk($sformatf("t1_act5_%0d", i), N'(active[5]), N'(t1[i].exp_a5));
        end
        bus.VEC_ACK   = 1'b0;
        bus.EOI_VALID = 1'b0;
        irq[5] = 1'b0;
        eoi(5);
        step();

        // 2: three edge lines in round-robin order
        do_reset();
        mask = '1;
        edge_sel[3] = 1'b1; edge_sel[7] = 1'b1; edge_sel[200] = 1'b1;
        irq[3] = 1'b1; irq[7] = 1'b1; irq[200] = 1'b1;
        step();
        irq = '0;
        wait_offer(3, "t2_a");   ack();
        wait_offer(7, "t2_b");   ack();
        wait_offer(200, "t2_c"); ack();
        chk("t2_ptr", N'(dut.ptr_q), N'(201));
        chk("t2_epend", dut.epend_q, '0);

        // 3: pointer wrap 238 -> 239 -> 0 -> 1
        do_reset();
        mask = '1;
        irq[238] = 1'b1;
        wait_offer(238, "t3_a");
        irq[238] = 1'b0; irq[239] = 1'b1; irq[1] = 1'b1;
        ack();
        chk("t3_ptr239", N'(dut.ptr_q), N'(239));
        wait_offer(239, "t3_b"); ack();
        chk("t3_ptr0", N'(dut.ptr_q), N'(0));
        wait_offer(1, "t3_c"); ack();

        // 4: edge on an active line re-offered exactly once after EOI
        do_reset();
        mask = '1;
        edge_sel[10] = 1'b1;
        irq[10] = 1'b1; step(); irq[10] = 1'b0;
        wait_offer(10, "t4_a"); ack();
        chk("t4_act10", N'(active[10]), N'(1));
        irq[10] = 1'b1; step(); irq[10] = 1'b0;
        repeat (5) step();
        chk("t4_no_offer", N'(bus.VEC_VALID), N'(0));
        chk("t4_epend10", N'(dut.epend_q[10]), N'(1));
        eoi(10);
        wait_offer(10, "t4_b"); ack();
        cnt = 0;
        repeat (10) begin
            step();
            if (bus.VEC_VALID) cnt++;
        end
        chk("t4_extra_offers", N'(cnt), N'(0));

        // 5: offer held through deassert/mask; stray EOI ignored
        do_reset();
        mask = '1;
        irq[4] = 1'b1;
        wait_offer(4, "t5_a");
        irq[4] = 1'b0; mask[4] = 1'b0;
        bus.EOI_VALID = 1'b1; bus.EOI_ID = IDW'(99);
        step();
        bus.EOI_VALID = 1'b0;
        repeat (4) begin
            step();
            chk("t5_hold_valid", N'(bus.VEC_VALID), N'(1));
            chk("t5_hold_id", N'(bus.VEC_ID), N'(4));
        end
        chk("t5_active_none", active, '0);
        ack();
        e = '0; e[4] = 1'b1;
        chk("t5_active4", active, e);

        // 6: async reset mid-offer, level line re-offered after release
        do_reset();
        mask = '1;
        irq[20] = 1'b1; irq[21] = 1'b1;
        wait_offer(20, "t6_a"); ack();
        wait_offer(21, "t6_b");
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", N'(bus.VEC_VALID), N'(0));
        chk("t6_async_active", active, '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("t6_gap", N'(bus.VEC_VALID), N'(0));
        step();
        chk("t6_re_valid", N'(bus.VEC_VALID), N'(1));
        chk("t6_re_id", N'(bus.VEC_ID), N'(20));

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < N; n++) begin
            edge_sel[n] = 1'($urandom_range(0, 1));
            mask[n]     = ($urandom_range(0, 3) != 0);
        end
        for (int c = 0; c < 3000; c++) begin
            repeat (2) begin
                idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1))
                                                 : int'($urandom_range(0, 15));
                irq[idx] = ~irq[idx];
            end
            if ($urandom_range(0, 15) == 0) begin
                idx = int'($urandom_range(0, 15));
                mask[idx] = ~mask[idx];
            end
            bus.VEC_ACK   = 1'($urandom_range(0, 1));
            bus.EOI_VALID = ($urandom_range(0, 2) == 0);
            bus.EOI_ID    = ($urandom_range(0, 3) == 0) ? IDW'($urandom_range(0, 255))
                                                       : IDW'($urandom_range(0, 15));
            step();
        end
        bus.VEC_ACK   = 1'b0;
        bus.EOI_VALID = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
